// File: rtl/alu_issue_unit.sv
// alu_issue_unit: sequential issuer for an 8-bit combinational ALU.
// Accepts 16-bit instruction words, reads operands from a 4x8 register
// file, drives the ALU for one cycle and commits result and flags.
//
// Handshake: an instruction word is transferred on a rising clock edge where
// in_valid and in_ready are both high. in_ready is high only in IDLE and does
// not depend on in_valid. A word presented while the unit is busy simply waits
// and is taken on the first IDLE edge.
//
// dbg_state exposes the FSM state: 0 = IDLE, 1 = EXEC, 2 = WB.
module alu_issue_unit #(
  parameter int NREGS = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_instr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_fn,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [2:0]       alu_flags,
  output logic [2:0]       flags_q,
  output logic             done,
  output logic             illegal,
  input  logic [1:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  // Instruction class latched at accept.
  localparam logic [1:0] K_ALU = 2'd0;
  localparam logic [1:0] K_LDI = 2'd1;
  localparam logic [1:0] K_ILL = 2'd2;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [3:0]       r_alu_fn;
  logic [2:0]       r_flags;
  logic [1:0]       r_kind;
  logic [1:0]       r_rd;
  logic [WIDTH-1:0] r_imm;

  logic [3:0]       w_op;
  logic [1:0]       w_rd;
  logic [1:0]       w_ra;
  logic [1:0]       w_rb;
  logic [WIDTH-1:0] w_imm;
  logic [1:0]       w_kind;
  logic [3:0]       w_fn;
  logic [WIDTH-1:0] w_b;
  logic             w_accept;
  logic             w_commit;
  logic             w_is_arith;

  // Field extraction and instruction classification.
  always_comb begin
    w_op   = in_instr[15:12];
    w_rd   = in_instr[11:10];
    w_ra   = in_instr[9:8];
    w_rb   = in_instr[1:0];
    w_imm  = WIDTH'(in_instr[7:0]);
    w_kind = K_ILL;
    if (w_op <= 4'h4) begin
      w_kind = K_ALU;
    end else if (w_op == 4'h5) begin
      w_kind = K_LDI;
    end else if (w_op >= 4'h8 && w_op <= 4'hC) begin
      w_kind = K_ALU;
    end
    // Immediate forms (op[3]=1) map onto the same function codes as the
    // register forms and take operand b from the low byte of the word.
    w_fn = w_op[3] ? {1'b0, w_op[2:0]} : w_op;
    w_b  = w_op[3] ? w_imm : r_regs[w_rb];
  end

  assign w_accept   = (r_state == S_IDLE) && in_valid;
  assign w_commit   = (r_state == S_EXEC);
  // Only ADD and SUB produce a meaningful overflow flag.
  assign w_is_arith = (r_alu_fn == 4'h0) || (r_alu_fn == 4'h1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: IDLE -> EXEC -> WB -> IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_WB;
      S_WB:    w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from state and the latched instruction class.
  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;
    case (r_state)
      S_IDLE: in_ready = 1'b1;
      S_WB: begin
        done    = (r_kind != K_ILL);
        illegal = (r_kind == K_ILL);
      end
      default: ;
    endcase
  end

  // Operand/function registers and latched decode, loaded on accept only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_fn <= 4'h0;
      r_kind   <= K_ALU;
      r_rd     <= 2'd0;
      r_imm    <= '0;
    end else if (w_accept) begin
      r_alu_a  <= r_regs[w_ra];
      r_alu_b  <= w_b;
      r_alu_fn <= w_fn;
      r_kind   <= w_kind;
      r_rd     <= w_rd;
      r_imm    <= w_imm;
    end
  end

  // Register file writeback at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      if (r_kind == K_ALU) begin
        r_regs[r_rd] <= alu_result;
      end else if (r_kind == K_LDI) begin
        r_regs[r_rd] <= r_imm;
      end
    end
  end

  // Flag register: written only by ALU ops; overflow masked for logic ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 3'b000;
    end else if (w_commit && (r_kind == K_ALU)) begin
      r_flags <= {alu_flags[2:1], alu_flags[0] & w_is_arith};
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_fn    = r_alu_fn;
  assign flags_q   = r_flags;
  assign dbg_data  = r_regs[dbg_sel];
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Testbench for alu_issue_unit: directed scenarios plus random instruction
// streams, checked against a behavioural model of the register file/flags.
module tb_alu_issue_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_fn;
  logic [7:0]  alu_result;
  logic [2:0]  alu_flags;
  logic [2:0]  flags_q;
  logic        done;
  logic        illegal;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference state.
  logic [7:0] model_r [4];
  logic [2:0] model_flags;
  logic [7:0] exp_q [$];

  alu_issue_unit #(.NREGS(4), .WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_fn     (alu_fn),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .flags_q    (flags_q),
    .done       (done),
    .illegal    (illegal),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Combinational ALU stand-in. For logic ops it drives a junk overflow bit,
  // which the unit must mask.
  always_comb begin
    logic [7:0] r;
    logic       v;
    r = 8'h00;
    v = 1'b0;
    case (alu_fn)
      4'h0: begin r = alu_a + alu_b; v = (alu_a[7] == alu_b[7]) && (r[7] != alu_a[7]); end
      4'h1: begin r = alu_a - alu_b; v = (alu_a[7] != alu_b[7]) && (r[7] != alu_a[7]); end
      4'h2: begin r = alu_a & alu_b; v = alu_a[0] ^ alu_b[1]; end
      4'h3: begin r = alu_a | alu_b; v = alu_a[0] ^ alu_b[1]; end
      4'h4: begin r = alu_a ^ alu_b; v = alu_a[0] ^ alu_b[1]; end
      default: begin r = 8'h00; v = 1'b1; end
    endcase
    alu_result = r;
    alu_flags  = {(r == 8'h00), r[7], v};
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU using signed integer arithmetic for overflow.
  function automatic void ref_alu(input logic [3:0] fn, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] res, output logic [2:0] fl);
    int sa, sb, sr;
    bit ovf;
    sa = int'(a); if (sa > 127) sa -= 256;
    sb = int'(b); if (sb > 127) sb -= 256;
    ovf = 1'b0;
    res = 8'h00;
    case (fn)
      4'h0: begin sr = sa + sb; ovf = (sr > 127) || (sr < -128); res = 8'(sr); end
      4'h1: begin sr = sa - sb; ovf = (sr > 127) || (sr < -128); res = 8'(sr); end
      4'h2: res = a & b;
      4'h3: res = a | b;
      4'h4: res = a ^ b;
      default: res = 8'h00;
    endcase
    fl = {(res == 8'h00), res[7], ovf};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model_r[i] = 8'h00;
    model_flags = 3'b000;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  // Called in IDLE between a falling edge and the next rising edge; returns
  // in the following IDLE cycle shortly after its falling edge.
  task automatic run_instr(input logic [15:0] instr, input bit keep_valid);
    int n;
    logic [3:0] op, fn;
    logic [1:0] rd, ra, rb;
    logic [7:0] a, b, res;
    logic [2:0] fl;
    bit is_alu, is_ldi, is_ill;
    in_valid = 1'b1;
    in_instr = instr;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 16'(in_ready), 16'd1);
      in_valid = 1'b0;
      return;
    end
    op = instr[15:12]; rd = instr[11:10]; ra = instr[9:8]; rb = instr[1:0];
    is_alu = (op <= 4'h4) || (op >= 4'h8 && op <= 4'hC);
    is_ldi = (op == 4'h5);
    is_ill = !is_alu && !is_ldi;
    fn = 4'h0; a = 8'h00; b = 8'h00; res = 8'h00; fl = 3'b000;
    if (is_alu) begin
      fn = (op <= 4'h4) ? op : op - 4'h8;
      a  = model_r[ra];
      b  = (op <= 4'h4) ? model_r[rb] : instr[7:0];
      ref_alu(fn, a, b, res, fl);
    end
    @(posedge clk);
    if (is_alu) begin
      model_r[rd] = res;
      model_flags = fl;
      exp_q.push_back(res);
    end else if (is_ldi) begin
      model_r[rd] = instr[7:0];
      exp_q.push_back(instr[7:0]);
    end
    // EXEC cycle
    @(negedge clk);
    if (!keep_valid) in_valid = 1'b0;
    chk("exec_state", 16'(dbg_state), 16'd1);
    chk("exec_ready", 16'(in_ready), 16'd0);
    chk("exec_done", 16'(done), 16'd0);
    chk("exec_illegal", 16'(illegal), 16'd0);
    if (is_alu) begin
      chk("exec_fn", 16'(alu_fn), 16'(fn));
      chk("exec_a", 16'(alu_a), 16'(a));
      chk("exec_b", 16'(alu_b), 16'(b));
    end
    // WB cycle
    @(negedge clk);
    chk("wb_state", 16'(dbg_state), 16'd2);
    chk("wb_ready", 16'(in_ready), 16'd0);
    chk("wb_done", 16'(done), 16'(!is_ill));
    chk("wb_illegal", 16'(illegal), 16'(is_ill));
    chk("wb_flags", 16'(flags_q), 16'(model_flags));
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      if (!is_ill && i == int'(rd)) begin
        chk("wb_dest", 16'(dbg_data), 16'(exp_q.pop_front()));
      end else begin
        chk("wb_reg", 16'(dbg_data), 16'(model_r[i]));
      end
    end
    // back in IDLE
    @(negedge clk);
    chk("idle_state", 16'(dbg_state), 16'd0);
    chk("idle_ready", 16'(in_ready), 16'd1);
    chk("idle_done", 16'(done), 16'd0);
    chk("idle_illegal", 16'(illegal), 16'd0);
  endtask

  // Spot check against literal values from the scenario description.
  task automatic spot(input string tag, input logic [1:0] sel, input logic [7:0] val,
                      input logic [2:0] fl);
    dbg_sel = sel;
    #1;
    chk({tag, "_reg"}, 16'(dbg_data), 16'(val));
    chk({tag, "_flags"}, 16'(flags_q), 16'(fl));
  endtask

  // Reset asserted during EXEC; in_valid stays high across the reset.
  task automatic reset_mid_op(input logic [15:0] instr);
    in_valid = 1'b1;
    in_instr = instr;
    chk("rst_pre_ready", 16'(in_ready), 16'd1);
    @(posedge clk);
    @(negedge clk);
    chk("rst_exec_state", 16'(dbg_state), 16'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_state", 16'(dbg_state), 16'd0);
    chk("rst_ready", 16'(in_ready), 16'd1);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_flags", 16'(flags_q), 16'd0);
    for (int i = 0; i < 3; i++) begin
      dbg_sel = 2'(i + 1);
      #1;
      chk("rst_reg", 16'(dbg_data), 16'h00);
    end
    @(negedge clk);
    chk("rst_done_hold", 16'(done), 16'd0);
    rst_n = 1'b1;
    run_instr(instr, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] w;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_instr = 16'h0000;
    dbg_sel  = 2'd0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // Reset state
    chk("reset_ready", 16'(in_ready), 16'd1);
    chk("reset_flags", 16'(flags_q), 16'd0);
    chk("reset_done", 16'(done), 16'd0);
    chk("reset_illegal", 16'(illegal), 16'd0);
    chk("reset_alu_fn", 16'(alu_fn), 16'd0);
    chk("reset_alu_a", 16'(alu_a), 16'd0);
    chk("reset_alu_b", 16'(alu_b), 16'd0);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      chk("reset_reg", 16'(dbg_data), 16'h00);
    end

    // Directed sequence
    run_instr(16'h547F, 1'b0);          // LDI R1 = 0x7F
    run_instr(16'h5801, 1'b0);          // LDI R2 = 0x01
    run_instr(16'h0D02, 1'b0);          // ADD R3 = R1 + R2
    spot("add", 2'd3, 8'h80, 3'b011);
    run_instr(16'h917F, 1'b0);          // SUB R0 = R1 - 0x7F
    spot("subi", 2'd0, 8'h00, 3'b100);
    run_instr(16'h2301, 1'b0);          // AND R0 = R3 & R1
    spot("and", 2'd0, 8'h00, 3'b100);
    run_instr(16'h1702, 1'b0);          // SUB R1 = R3 - R2
    spot("sub", 2'd1, 8'h7F, 3'b001);
    run_instr(16'hF123, 1'b0);          // illegal
    spot("illegal", 2'd1, 8'h7F, 3'b001);
    run_instr(16'h5C55, 1'b0);          // LDI R3 = 0x55 after illegal
    run_instr(16'h0A02, 1'b1);          // ADD R2 = R2 + R2, valid held
    run_instr(16'h0A02, 1'b0);          // same word taken in next IDLE
    run_instr(16'hC4A5, 1'b0);          // XOR R1 = R0 ^ 0xA5 (junk ovf)
    run_instr(16'hD000, 1'b0);          // illegal
    repeat (2) @(negedge clk);

    // Reset during EXEC of ADD R3 = R1 + R2
    run_instr(16'h5433, 1'b0);
    run_instr(16'h5844, 1'b0);
    reset_mid_op(16'h0D02);
    spot("post_rst", 2'd3, 8'h00, 3'b100);

    // Random streams
    for (int i = 0; i < 60; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 3) == 0) w[15:12] = 4'h5;
      run_instr(w, (i < 59) ? 1'($urandom_range(0, 1)) : 1'b0);
      if (!in_valid && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
